// File: rtl/eth_frame_tx.sv
// Ethernet frame builder: buffers one payload, then streams it out as
// destination MAC, source MAC, 16-bit length, payload and zero padding.
//
// state   | meaning
// --------+---------------------------------------------------------
// COLLECT | accepting payload bytes into the buffer
// HDR     | emitting the 12 MAC address bytes (dst then src)
// LEN     | emitting the payload length, high byte first
// PAYLOAD | emitting buffered payload bytes in arrival order
// PAD     | emitting fill bytes up to the minimum payload size
// DONE    | frame_done pulse cycle; clears the count for the next frame
module eth_frame_tx #(
  parameter logic [47:0] DST_MAC     = 48'h6805ca2a4e23,
  parameter logic [47:0] SRC_MAC     = 48'h26731bc9110c,
  parameter int          MAX_PAYLOAD = 64,
  parameter int          MIN_PAYLOAD = 46,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_eth_wdata,
  output logic       o_eth_wvalid,
  input  logic       i_eth_wready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int          AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] MAX_N   = 16'(MAX_PAYLOAD);
  localparam logic [15:0] MIN_N   = 16'(MIN_PAYLOAD);
  localparam logic [95:0] MAC_HDR = {DST_MAC, SRC_MAC};

  typedef enum logic [2:0] {COLLECT, HDR, LEN, PAYLOAD, PAD, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] n, n_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        ready_nxt, wvalid_nxt, busy_nxt, done_nxt;
  logic [7:0]  wdata_nxt;
  logic        accept, xfer;
  logic [AW-1:0] rd_idx;
  logic [7:0]  mem [MAX_PAYLOAD];

  // Header byte k of the 12-byte MAC address block, MSB byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0] k);
    hdr_byte = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (k == 4'(i)) hdr_byte = MAC_HDR[95-8*i -: 8];
    end
  endfunction

  assign accept = i_valid & o_ready;
  assign xfer   = o_eth_wvalid & i_eth_wready;
  assign rd_idx = cnt[AW-1:0] + AW'(1);

  // Payload buffer; no reset needed since N bounds every read.
  always_ff @(posedge i_clk) begin
    if (accept) mem[n[AW-1:0]] <= i_data;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= COLLECT;
      n            <= '0;
      cnt          <= '0;
      o_ready      <= 1'b0;
      o_eth_wvalid <= 1'b0;
      o_eth_wdata  <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      n            <= n_nxt;
      cnt          <= cnt_nxt;
      o_ready      <= ready_nxt;
      o_eth_wvalid <= wvalid_nxt;
      o_eth_wdata  <= wdata_nxt;
      o_busy       <= busy_nxt;
      o_frame_done <= done_nxt;
    end
  end

  // Next state and next output values; the byte to present after each
  // transfer is chosen here so the output stays registered without bubbles.
  always_comb begin
    state_nxt  = state;
    n_nxt      = n;
    cnt_nxt    = cnt;
    ready_nxt  = o_ready;
    wvalid_nxt = o_eth_wvalid;
    wdata_nxt  = o_eth_wdata;
    busy_nxt   = o_busy;
    done_nxt   = 1'b0;
    case (state)
      COLLECT: begin
        ready_nxt = 1'b1;
        if (accept) begin
          n_nxt = n + 16'd1;
          if (i_last || (n + 16'd1 == MAX_N)) begin
            state_nxt  = HDR;
            ready_nxt  = 1'b0;
            wvalid_nxt = 1'b1;
            wdata_nxt  = hdr_byte(4'd0);
            busy_nxt   = 1'b1;
            cnt_nxt    = '0;
          end
        end
      end
      HDR: begin
        if (xfer) begin
          if (cnt == 16'd11) begin
            state_nxt = LEN;
            cnt_nxt   = '0;
            wdata_nxt = n[15:8];
          end else begin
            cnt_nxt   = cnt + 16'd1;
            wdata_nxt = hdr_byte(cnt[3:0] + 4'd1);
          end
        end
      end
      LEN: begin
        if (xfer) begin
          if (cnt == 16'd0) begin
            cnt_nxt   = 16'd1;
            wdata_nxt = n[7:0];
          end else begin
            state_nxt = PAYLOAD;
            cnt_nxt   = '0;
            wdata_nxt = mem[0];
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (cnt == n - 16'd1) begin
            cnt_nxt = '0;
            if (n < MIN_N) begin
              state_nxt = PAD;
              wdata_nxt = PAD_BYTE;
            end else begin
              state_nxt  = DONE;
              wvalid_nxt = 1'b0;
              busy_nxt   = 1'b0;
              done_nxt   = 1'b1;
            end
          end else begin
            cnt_nxt   = cnt + 16'd1;
            wdata_nxt = mem[rd_idx];
          end
        end
      end
      PAD: begin
        if (xfer) begin
          if (cnt == MIN_N - n - 16'd1) begin
            state_nxt  = DONE;
            cnt_nxt    = '0;
            wvalid_nxt = 1'b0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      DONE: begin
        state_nxt = COLLECT;
        n_nxt     = '0;
        cnt_nxt   = '0;
        ready_nxt = 1'b1;
      end
      default: state_nxt = COLLECT;
    endcase
  end

endmodule
